// File: rtl/spm_ctrl.sv
// Dual-port scratchpad memory controller: zero-fill sweep after reset, then two
// independent ports with 1-cycle registered reads and cross-port write forwarding.
module spm_ctrl #(
  parameter int SPM_ADDR_W  = 12,
  parameter int WORD_DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SPM_ADDR_W-1:0]  a_addr,
  input  logic                   a_as_,
  input  logic                   a_rw,
  input  logic [WORD_DATA_W-1:0] a_wr_data,
  output logic [WORD_DATA_W-1:0] a_rd_data,
  output logic                   a_rd_valid,
  input  logic [SPM_ADDR_W-1:0]  b_addr,
  input  logic                   b_as_,
  input  logic                   b_rw,
  input  logic [WORD_DATA_W-1:0] b_wr_data,
  output logic [WORD_DATA_W-1:0] b_rd_data,
  output logic                   b_rd_valid,
  output logic                   busy
);

  localparam int   DEPTH = 1 << SPM_ADDR_W;
  localparam logic READ  = 1'b1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  logic [SPM_ADDR_W-1:0] r_init_idx;
  logic                  r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_idx <= r_init_idx + SPM_ADDR_W'(1);
          if (r_init_idx == '1) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy = r_busy;

  // Index 0 is port A, index 1 is port B; the per-port logic is generated once.
  logic                   w_run;
  logic                   w_init_we;
  logic [SPM_ADDR_W-1:0]  w_addr      [2];
  logic                   w_as_n      [2];
  logic                   w_rw        [2];
  logic [WORD_DATA_W-1:0] w_wdata     [2];
  logic                   w_wr_acc    [2];
  logic                   w_rd_acc    [2];
  logic [WORD_DATA_W-1:0] w_rd_data   [2];
  logic                   w_rd_valid  [2];
  logic                   w_mem_we    [2];
  logic [SPM_ADDR_W-1:0]  w_mem_addr  [2];
  logic [WORD_DATA_W-1:0] w_mem_wdata [2];

  logic [WORD_DATA_W-1:0] mem [DEPTH];

  assign w_run     = (r_state == ST_RUN) && !reset;
  assign w_init_we = (r_state == ST_INIT) && !reset;

  assign w_addr[0]  = a_addr;
  assign w_as_n[0]  = a_as_;
  assign w_rw[0]    = a_rw;
  assign w_wdata[0] = a_wr_data;
  assign w_addr[1]  = b_addr;
  assign w_as_n[1]  = b_as_;
  assign w_rw[1]    = b_rw;
  assign w_wdata[1] = b_wr_data;

  // The zero-fill sweep borrows port A's write path; user traffic is blocked then.
  assign w_mem_we[0]    = w_init_we || w_wr_acc[0];
  assign w_mem_addr[0]  = w_init_we ? r_init_idx : w_addr[0];
  assign w_mem_wdata[0] = w_init_we ? '0 : w_wdata[0];
  assign w_mem_we[1]    = w_wr_acc[1];
  assign w_mem_addr[1]  = w_addr[1];
  assign w_mem_wdata[1] = w_wdata[1];

  // Port B is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (w_mem_we[0]) mem[w_mem_addr[0]] <= w_mem_wdata[0];
    if (w_mem_we[1]) mem[w_mem_addr[1]] <= w_mem_wdata[1];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam int OTHER = 1 - gi;

      logic [WORD_DATA_W-1:0] r_ram_q;
      logic [WORD_DATA_W-1:0] r_fwd_data;
      logic [WORD_DATA_W-1:0] r_hold;
      logic                   r_fwd;
      logic                   r_rd_valid;

      assign w_rd_acc[gi] = w_run && !w_as_n[gi] && (w_rw[gi] == READ);
      assign w_wr_acc[gi] = w_run && !w_as_n[gi] && (w_rw[gi] != READ);

      always_ff @(posedge clk) begin
        if (w_rd_acc[gi]) r_ram_q <= mem[w_addr[gi]];
      end

      // The array reads old data; a same-cycle write from the other port is
      // captured beside it and substituted on the output.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rd_valid <= 1'b0;
          r_fwd      <= 1'b0;
          r_hold     <= '0;
        end else begin
          r_rd_valid <= w_rd_acc[gi];
          if (w_rd_acc[gi]) begin
            r_fwd      <= w_wr_acc[OTHER] && (w_addr[OTHER] == w_addr[gi]);
            r_fwd_data <= w_wdata[OTHER];
          end
          if (r_rd_valid) r_hold <= w_rd_data[gi];
        end
      end

      assign w_rd_data[gi]  = r_rd_valid ? (r_fwd ? r_fwd_data : r_ram_q) : r_hold;
      assign w_rd_valid[gi] = r_rd_valid;
    end
  endgenerate

  assign a_rd_data  = w_rd_data[0];
  assign a_rd_valid = w_rd_valid[0];
  assign b_rd_data  = w_rd_data[1];
  assign b_rd_valid = w_rd_valid[1];

endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl: directed vector table, hand-written reset/sweep sequences
// and random traffic checked against a word-array reference model.
module tb_spm_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_as_, b_as_, a_rw, b_rw;
  logic [DW-1:0] a_wr_data, b_wr_data;
  logic [DW-1:0] a_rd_data, b_rd_data;
  logic          a_rd_valid, b_rd_valid, busy;

  spm_ctrl #(.SPM_ADDR_W(AW), .WORD_DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_as_(a_as_), .a_rw(a_rw), .a_wr_data(a_wr_data),
    .a_rd_data(a_rd_data), .a_rd_valid(a_rd_valid),
    .b_addr(b_addr), .b_as_(b_as_), .b_rw(b_rw), .b_wr_data(b_wr_data),
    .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: word array, remaining sweep cycles, per-port read result.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = 0;
  logic          m_busy = 1'b1;
  logic          m_av = 1'b0, m_bv = 1'b0;
  logic [DW-1:0] m_ad = '0, m_bd = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    logic ok, ra, wa, rb, wb;
    if (reset) begin
      m_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_av = 1'b0; m_bv = 1'b0; m_ad = '0; m_bd = '0;
    end else begin
      ok = (m_left == 0);
      if (m_left > 0) m_left--;
      ra = ok && !a_as_ && a_rw;
      wa = ok && !a_as_ && !a_rw;
      rb = ok && !b_as_ && b_rw;
      wb = ok && !b_as_ && !b_rw;
      m_av = ra;
      m_bv = rb;
      if (ra) m_ad = (wb && b_addr == a_addr) ? b_wr_data : m_mem[a_addr];
      if (rb) m_bd = (wa && a_addr == b_addr) ? a_wr_data : m_mem[b_addr];
      if (wa) m_mem[a_addr] = a_wr_data;
      if (wb) m_mem[b_addr] = b_wr_data;
    end
    m_busy = (m_left > 0);
  endtask

  // One clock: update model, cross the edge, compare away from the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy",       {31'b0, busy},       {31'b0, m_busy});
    chk("a_rd_valid", {31'b0, a_rd_valid}, {31'b0, m_av});
    chk("a_rd_data",  a_rd_data,           m_ad);
    chk("b_rd_valid", {31'b0, b_rd_valid}, {31'b0, m_bv});
    chk("b_rd_data",  b_rd_data,           m_bd);
  endtask

  task automatic drive(input logic aas, input logic arw, input logic [AW-1:0] aa, input logic [DW-1:0] awd,
                       input logic bas, input logic brw, input logic [AW-1:0] ba, input logic [DW-1:0] bwd);
    a_as_ = aas; a_rw = arw; a_addr = aa; a_wr_data = awd;
    b_as_ = bas; b_rw = brw; b_addr = ba; b_wr_data = bwd;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, '0, '0, 1'b1, 1'b1, '0, '0);
  endtask

  // Ticks until busy drops, bounded; returns the number of ticks taken.
  task automatic run_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic          a_as_n; logic a_rw; logic [AW-1:0] a_addr; logic [DW-1:0] a_wd;
    logic          b_as_n; logic b_rw; logic [AW-1:0] b_addr; logic [DW-1:0] b_wd;
    logic          exp_av; logic [DW-1:0] exp_ad;
    logic          exp_bv; logic [DW-1:0] exp_bd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    // READ=1, WRITE=0, as_ active low
    tbl[0] = '{1'b1, 1'b1, 4'd0, 32'h0,        1'b0, 1'b0, 4'd5, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 4'd5, 32'h0,        1'b1, 1'b1, 4'd0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 4'd0, 32'h0,        1'b1, 1'b1, 4'd0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 4'd9, 32'h0,        1'b0, 1'b0, 4'd9, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 4'd3, 32'h1111,     1'b0, 1'b0, 4'd3, 32'h2222,     1'b0, 32'h12345678, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 4'd3, 32'h0,        1'b0, 1'b1, 4'd3, 32'h0,        1'b1, 32'h2222,     1'b1, 32'h2222};
    tbl[6] = '{1'b0, 1'b0, 4'd7, 32'hABCD,     1'b0, 1'b1, 4'd7, 32'h0,        1'b0, 32'h2222,     1'b1, 32'hABCD};
    tbl[7] = '{1'b0, 1'b1, 4'd7, 32'h0,        1'b0, 1'b1, 4'd2, 32'h0,        1'b1, 32'hABCD,     1'b1, 32'h0};
    tbl[8] = '{1'b1, 1'b1, 4'd9, 32'h0,        1'b1, 1'b1, 4'd0, 32'h0,        1'b0, 32'hABCD,     1'b0, 32'h0};
    tbl[9] = '{1'b0, 1'b1, 4'd5, 32'h0,        1'b0, 1'b1, 4'd9, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678};

    // Reset state
    reset = 1'b1;
    idle();
    tick();
    $display("reset: busy=%0d a_v=%0d a_d=%h b_v=%0d b_d=%h", busy, a_rd_valid, a_rd_data, b_rd_valid, b_rd_data);
    chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_a_data", a_rd_data, 32'h0);

    // Blocked access during the sweep; sweep length 16 cycles
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'd2, 32'hFFFF, 1'b0, 1'b1, 4'd2, 32'h0);
    run_sweep(n);
    $display("sweep: %0d cycles", n);
    chk("sweep_len", n, 32'd16);
    idle();

    // Every address reads zero after the sweep
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, AW'(i), '0, 1'b0, 1'b1, AW'(DEPTH - 1 - i), '0);
      tick();
      $display("zero read: a[%0d]=%h b[%0d]=%h", i, a_rd_data, DEPTH - 1 - i, b_rd_data);
      chk("zero_a_data",  a_rd_data, 32'h0);
      chk("zero_a_valid", {31'b0, a_rd_valid}, 32'd1);
      chk("zero_b_data",  b_rd_data, 32'h0);
    end

    // Directed table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a_as_n, tbl[i].a_rw, tbl[i].a_addr, tbl[i].a_wd,
            tbl[i].b_as_n, tbl[i].b_rw, tbl[i].b_addr, tbl[i].b_wd);
      tick();
      $display("vec %0d: a_v=%0d a_d=%h b_v=%0d b_d=%h", i, a_rd_valid, a_rd_data, b_rd_valid, b_rd_data);
      chk("tbl_a_valid", {31'b0, a_rd_valid}, {31'b0, tbl[i].exp_av});
      chk("tbl_a_data",  a_rd_data, tbl[i].exp_ad);
      chk("tbl_b_valid", {31'b0, b_rd_valid}, {31'b0, tbl[i].exp_bv});
      chk("tbl_b_data",  b_rd_data, tbl[i].exp_bd);
    end

    // Reset with a read in flight
    drive(1'b0, 1'b1, 4'd5, '0, 1'b1, 1'b1, '0, '0);
    tick();
    chk("inflight_valid", {31'b0, a_rd_valid}, 32'd1);
    reset = 1'b1;
    idle();
    tick();
    $display("mid reset: busy=%0d a_v=%0d a_d=%h", busy, a_rd_valid, a_rd_data);
    chk("midrst_a_valid", {31'b0, a_rd_valid}, 32'd0);
    chk("midrst_a_data",  a_rd_data, 32'h0);
    chk("midrst_busy",    {31'b0, busy}, 32'd1);
    reset = 1'b0;

    // Reset again partway through the sweep: it must restart from index 0
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_sweep(n);
    $display("restarted sweep: %0d cycles", n);
    chk("restart_len", n, 32'd16);
    drive(1'b0, 1'b1, 4'd5, '0, 1'b0, 1'b1, 4'd3, '0);
    tick();
    chk("cleared_a5", a_rd_data, 32'h0);
    chk("cleared_b3", b_rd_data, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 3, 1'($urandom), AW'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 9) < 3, 1'($urandom), AW'($urandom_range(0, 3)), $urandom);
      tick();
      $display("rand %0d: rst=%0d busy=%0d a_v=%0d a_d=%h b_v=%0d b_d=%h",
               i, reset, busy, a_rd_valid, a_rd_data, b_rd_valid, b_rd_data);
    end
    reset = 1'b0;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
